// File: rtl/addr_gen_pkg.sv
// Shared types and defaults for the multi-channel address generator.
package addr_gen_pkg;

    localparam int NCH_DEF = 4;
    localparam int AW_DEF  = 32;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_DONE = 2'd2
    } ch_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from the slot after the last grant.
module rr_arbiter #(
    parameter int NCH = 4,
    parameter int IDW = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           advance,
    output logic [NCH-1:0] gnt_onehot,
    output logic [IDW-1:0] gnt_id,
    output logic           any
);

    logic [IDW-1:0] ptr_q;

    always_comb begin : arb_search
        int idx;
        idx        = 0;
        gnt_onehot = '0;
        gnt_id     = '0;
        any        = 1'b0;
        for (int off = 1; off <= NCH; off++) begin
            idx = (int'(ptr_q) + off) % NCH;
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_onehot[idx] = 1'b1;
                gnt_id          = IDW'(idx);
            end
        end
    end

    // Pointer starts at the last slot so that slot 0 is preferred after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr_q <= IDW'(NCH - 1);
        else if (advance && any)
            ptr_q <= gnt_id;
    end

endmodule

// File: rtl/addr_gen_arb.sv
// NCH independent linear address generators sharing one registered
// valid/ready address bus through a round-robin arbiter.
module addr_gen_arb
    import addr_gen_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int AW  = AW_DEF,
    parameter int IDW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*AW-1:0] cfg_base,
    input  logic [NCH*AW-1:0] cfg_len,
    input  logic [NCH-1:0]    start,
    input  logic [NCH-1:0]    pause,
    output logic [AW-1:0]     addr,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic [IDW-1:0]    grant_id,
    output logic [NCH-1:0]    busy,
    output logic [NCH-1:0]    done
);

    localparam logic [AW-1:0] ONE = AW'(1);

    logic [NCH-1:0]         elig;
    logic [NCH-1:0]         gnt_oh;
    logic [IDW-1:0]         gnt_id;
    logic                   gnt_any;
    logic [NCH-1:0][AW-1:0] cand;
    logic [AW-1:0]          sel_addr;
    logic                   load;
    logic                   xfer;

    assign xfer = addr_valid & addr_ready;
    // Output register refills whenever it is empty or being drained this cycle.
    assign load = ~addr_valid | addr_ready;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t     st_q, st_d;
        logic [AW-1:0] base_q, len_q, iss_q, acc_q;
        logic          own_xfer, last_xfer, won, restart;

        assign own_xfer  = xfer && (grant_id == IDW'(i));
        assign last_xfer = own_xfer && ((acc_q + ONE) == len_q);
        assign won       = load && gnt_oh[i];
        assign restart   = start[i] && (st_q != CH_RUN);

        assign elig[i] = (st_q == CH_RUN) && !pause[i] && (iss_q < len_q);
        assign cand[i] = base_q + iss_q;
        assign busy[i] = (st_q == CH_RUN);
        assign done[i] = (st_q == CH_DONE);

        always_comb begin
            st_d = st_q;
            case (st_q)
                CH_IDLE, CH_DONE:
                    if (start[i])
                        st_d = (cfg_len[i*AW +: AW] == '0) ? CH_DONE : CH_RUN;
                CH_RUN:
                    if (last_xfer) st_d = CH_DONE;
                default:
                    st_d = CH_IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                st_q   <= CH_IDLE;
                base_q <= '0;
                len_q  <= '0;
                iss_q  <= '0;
                acc_q  <= '0;
            end else begin
                st_q <= st_d;
                if (restart) begin
                    base_q <= cfg_base[i*AW +: AW];
                    len_q  <= cfg_len[i*AW +: AW];
                    iss_q  <= '0;
                    acc_q  <= '0;
                end else begin
                    if (won)      iss_q <= iss_q + ONE;
                    if (own_xfer) acc_q <= acc_q + ONE;
                end
            end
        end
    end

    rr_arbiter #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .req        (elig),
        .advance    (load),
        .gnt_onehot (gnt_oh),
        .gnt_id     (gnt_id),
        .any        (gnt_any)
    );

    always_comb begin
        sel_addr = '0;
        for (int k = 0; k < NCH; k++)
            if (gnt_oh[k]) sel_addr = sel_addr | cand[k];
    end

    // A stalled beat holds; when nothing is eligible the bus empties after the drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr       <= '0;
            addr_valid <= 1'b0;
            grant_id   <= '0;
        end else if (load) begin
            addr_valid <= gnt_any;
            if (gnt_any) begin
                addr     <= sel_addr;
                grant_id <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_addr_gen_arb.sv
// Scoreboard bench for addr_gen_arb: expected beats are queued as stimulus is
// driven and compared at each bus transfer.
module tb_addr_gen_arb;

    localparam int NCH = 4;
    localparam int AW  = 32;
    localparam int IDW = 2;

    typedef struct {
        logic [IDW-1:0] id;
        logic [AW-1:0]  addr;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [NCH*AW-1:0] cfg_base;
    logic [NCH*AW-1:0] cfg_len;
    logic [NCH-1:0]    start;
    logic [NCH-1:0]    pause;
    logic [AW-1:0]     addr;
    logic              addr_valid;
    logic              addr_ready;
    logic [IDW-1:0]    grant_id;
    logic [NCH-1:0]    busy;
    logic [NCH-1:0]    done;

    int    tests;
    int    fails;
    beat_t exp_q[$];
    beat_t mon_b;

    addr_gen_arb #(.NCH(NCH), .AW(AW), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .start      (start),
        .pause      (pause),
        .addr       (addr),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .grant_id   (grant_id),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transfer monitor: every accepted beat must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && addr_valid && addr_ready) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL beat_unexpected: got id=%0d addr=%h, want no beat", grant_id, addr);
            end else begin
                mon_b = exp_q.pop_front();
                if (grant_id !== mon_b.id || addr !== mon_b.addr) begin
                    fails++;
                    $display("FAIL beat_order: got id=%0d addr=%h, want id=%0d addr=%h",
                             grant_id, addr, mon_b.id, mon_b.addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [AW-1:0] a);
        beat_t b;
        b.id   = IDW'(id);
        b.addr = a;
        exp_q.push_back(b);
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] b, input logic [AW-1:0] l);
        cfg_base[ch*AW +: AW] = b;
        cfg_len[ch*AW +: AW]  = l;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        start      = '0;
        pause      = '0;
        addr_ready = 1'b0;
        cfg_base   = '0;
        cfg_len    = '0;
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d beats outstanding, want 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        start      = '0;
        pause      = '0;
        addr_ready = 1'b0;
        cfg_base   = '0;
        cfg_len    = '0;
        #3;
        tests++;
        if (addr !== '0 || addr_valid !== 1'b0 || grant_id !== '0 || busy !== '0 || done !== '0) begin
            fails++;
            $display("FAIL reset_outputs: addr=%h v=%b id=%0d busy=%b done=%b, want all 0",
                     addr, addr_valid, grant_id, busy, done);
        end
        tick();
        rst = 1'b0;
        tick();
        tests++;
        if (addr_valid !== 1'b0 || busy !== '0) begin
            fails++;
            $display("FAIL reset_idle: v=%b busy=%b, want 0/0000", addr_valid, busy);
        end
    endtask

    // Channel 0 single stream with start-to-valid latency and done timing.
    task automatic run_single();
        logic [5:0] exp_v;
        logic [5:0] exp_d;
        exp_v = 6'b011110;
        exp_d = 6'b100000;
        addr_ready = 1'b1;
        set_ch(0, 32'h100, 32'd4);
        for (int k = 0; k < 4; k++) push(0, 32'h100 + AW'(k));
        start = 4'b0001;
        tick();
        start = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            tests++;
            if (addr_valid !== exp_v[k] || done[0] !== exp_d[k]) begin
                fails++;
                $display("FAIL single_timing[t+%0d]: v=%b done0=%b, want v=%b done0=%b",
                         k + 1, addr_valid, done[0], exp_v[k], exp_d[k]);
            end
            if (k == 0) begin
                tests++;
                if (busy[0] !== 1'b1) begin
                    fails++;
                    $display("FAIL single_busy: busy0=%b, want 1", busy[0]);
                end
            end
        end
        tick();
        wait_drain("single");
    endtask

    task automatic test_single();
        do_reset();
        run_single();
    endtask

    task automatic test_two_channels();
        do_reset();
        addr_ready = 1'b1;
        set_ch(0, 32'h0, 32'd3);
        set_ch(1, 32'h1000, 32'd3);
        for (int k = 0; k < 3; k++) begin
            push(0, 32'h0 + AW'(k));
            push(1, 32'h1000 + AW'(k));
        end
        start = 4'b0011;
        tick();
        start = '0;
        wait_drain("two_ch");
        tick();
        tests++;
        if (done !== 4'b0011 || busy !== '0) begin
            fails++;
            $display("FAIL two_ch_done: done=%b busy=%b, want 0011/0000", done, busy);
        end
    endtask

    task automatic test_stall();
        do_reset();
        addr_ready = 1'b1;
        set_ch(0, 32'h200, 32'd6);
        for (int k = 0; k < 6; k++) push(0, 32'h200 + AW'(k));
        start = 4'b0001;
        tick();
        start = '0;
        tick();
        tick();
        tick();
        addr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            tests++;
            if (exp_q.size() != 4 || addr_valid !== 1'b1 ||
                addr !== exp_q[0].addr || grant_id !== exp_q[0].id) begin
                fails++;
                $display("FAIL stall_hold[%0d]: v=%b addr=%h id=%0d left=%0d, want v=1 addr=%h id=0 left=4",
                         k, addr_valid, addr, grant_id, exp_q.size(), 32'h202);
            end
        end
        tick();
        addr_ready = 1'b1;
        wait_drain("stall");
        tick();
        tests++;
        if (done[0] !== 1'b1) begin
            fails++;
            $display("FAIL stall_done: done0=%b, want 1", done[0]);
        end
    endtask

    task automatic test_wrap_zero();
        do_reset();
        addr_ready = 1'b1;
        set_ch(2, 32'hFFFF_FFFE, 32'd4);
        set_ch(3, 32'h5000, 32'd0);
        push(2, 32'hFFFF_FFFE);
        push(2, 32'hFFFF_FFFF);
        push(2, 32'h0000_0000);
        push(2, 32'h0000_0001);
        start = 4'b1100;
        tick();
        start = '0;
        @(negedge clk);
        tests++;
        if (done[3] !== 1'b1 || busy[3] !== 1'b0 || busy[2] !== 1'b1) begin
            fails++;
            $display("FAIL zero_len: done3=%b busy3=%b busy2=%b, want 1/0/1", done[3], busy[3], busy[2]);
        end
        wait_drain("wrap");
        // start together with pause: running but not eligible
        set_ch(1, 32'h40, 32'd2);
        pause = 4'b0010;
        start = 4'b0010;
        tick();
        start = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (busy[1] !== 1'b1 || addr_valid !== 1'b0) begin
                fails++;
                $display("FAIL start_paused[%0d]: busy1=%b v=%b, want 1/0", k, busy[1], addr_valid);
            end
        end
        push(1, 32'h40);
        push(1, 32'h41);
        tick();
        pause = '0;
        wait_drain("start_paused");
    endtask

    task automatic test_pause();
        do_reset();
        addr_ready = 1'b1;
        set_ch(0, 32'h0, 32'd3);
        set_ch(1, 32'h1000, 32'd3);
        push(0, 32'h0);
        push(1, 32'h1000);
        push(0, 32'h1);
        push(0, 32'h2);
        start = 4'b0011;
        tick();
        start = '0;
        tick();
        tick();
        pause = 4'b0010;
        repeat (6) tick();
        tests++;
        if (exp_q.size() != 0 || busy[1] !== 1'b1 || done[0] !== 1'b1) begin
            fails++;
            $display("FAIL pause_hold: left=%0d busy1=%b done0=%b, want 0/1/1",
                     exp_q.size(), busy[1], done[0]);
        end
        push(1, 32'h1001);
        push(1, 32'h1002);
        pause = '0;
        wait_drain("pause_resume");
        tick();
        tests++;
        if (done[1] !== 1'b1) begin
            fails++;
            $display("FAIL pause_done: done1=%b, want 1", done[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        addr_ready = 1'b0;
        set_ch(0, 32'h100, 32'd4);
        start = 4'b0001;
        tick();
        start = '0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (addr_valid !== 1'b0 || busy !== '0 || done !== '0 || addr !== '0 || grant_id !== '0) begin
            fails++;
            $display("FAIL reset_mid: v=%b busy=%b done=%b addr=%h id=%0d, want all 0",
                     addr_valid, busy, done, addr, grant_id);
        end
        exp_q.delete();
        cfg_base = '0;
        cfg_len  = '0;
        tick();
        rst = 1'b0;
        run_single();
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_two_channels();
        test_stall();
        test_wrap_zero();
        test_pause();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
